// File: rtl/cam_mux_pkg.sv
// Shared helpers and defaults for the CAM datapath selector blocks.
package cam_mux_pkg;

    // Leaf mux width used when the instantiating block does not override it.
    localparam int DEFAULT_RADIX = 8;

    // Width of an index able to address n items, never below one bit so that
    // degenerate selects (n <= 2) still produce a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipelined_tree_mux_param_mux.sv
// Combinational RADIX-to-1 selector, DATA_WIDTH bits per input.
// RADIX is expected to be a power of two so every sel code addresses an input.
module param_mux
    import cam_mux_pkg::*;
#(
    parameter  int RADIX      = DEFAULT_RADIX,
    parameter  int DATA_WIDTH = 1,
    localparam int SEL_W      = clog2_min1(RADIX)
) (
    input  logic [RADIX-1:0][DATA_WIDTH-1:0] data,
    input  logic [SEL_W-1:0]                 sel,
    output logic [DATA_WIDTH-1:0]            y
);

    generate
        if (RADIX == 1) begin : gPass
            // A single input needs no decode; the select code is don't-care.
            logic unusedSel;
            assign unusedSel = ^sel;
            assign y         = data[0];
        end else begin : gMux
            // Plain indexed pick of the addressed input.
            always_comb begin
                y = data[sel];
            end
        end
    endgenerate

endmodule

// File: rtl/pipelined_tree_mux.sv
// Two-stage pipelined N-to-1 selector for the CAM datapath.
// S1 registers every leaf mux result plus the group index and range error;
// S2 picks the group and registers the final lane with valid/ready flow control.
module pipelined_tree_mux
    import cam_mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 32,
    parameter  int DATA_WIDTH = 1,
    parameter  int RADIX      = DEFAULT_RADIX,
    localparam int SEL_W      = clog2_min1(NUM_INPUTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]               in_sel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_err
);

    localparam int GROUPS     = NUM_INPUTS / RADIX;
    localparam int LEAF_SEL_W = $clog2(RADIX);
    localparam int GRP_SEL_W  = clog2_min1(GROUPS);
    // The root mux is sized up to a power of two; spare inputs read as zero.
    localparam int GRP_POW2   = 1 << $clog2(GROUPS);

    typedef struct packed {
        logic                 err;
        logic [GRP_SEL_W-1:0] grp;
    } s1Side_t;

    // vldPipe[1] = S1 occupied, vldPipe[2] = S2 occupied (drives out_valid).
    logic [2:1] vldPipe;
    logic       s1Ready;
    logic       s2Ready;

    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lanes;
    logic [GROUPS-1:0][DATA_WIDTH-1:0]     leafOut;
    logic [GROUPS-1:0][DATA_WIDTH-1:0]     leafQ;
    logic [GRP_POW2-1:0][DATA_WIDTH-1:0]   rootIn;
    logic [DATA_WIDTH-1:0]                 rootOut;

    logic                 selErr;
    logic [GRP_SEL_W-1:0] selGrp;
    s1Side_t              s1Side;

    assign lanes = in_data;

    // Ready chain looks only at pipeline occupancy and the consumer, never at
    // in_valid, so upstream can treat in_ready as a pure status signal.
    assign s2Ready   = !vldPipe[2] || out_ready;
    assign s1Ready   = !vldPipe[1] || s2Ready;
    assign in_ready  = s1Ready && !reset;
    assign out_valid = vldPipe[2];

    generate
        // Range error only exists when the lane count leaves unused sel codes.
        if (NUM_INPUTS == (1 << SEL_W)) begin : gNoErr
            assign selErr = 1'b0;
        end else begin : gErr
            assign selErr = (in_sel >= SEL_W'(NUM_INPUTS));
        end

        // With a single group the upper select bits do not exist.
        if (GROUPS > 1) begin : gGrp
            assign selGrp = GRP_SEL_W'(in_sel >> LEAF_SEL_W);
        end else begin : gOneGrp
            assign selGrp = '0;
        end

        // One leaf mux per group, all driven by the low select bits.
        for (genvar g = 0; g < GROUPS; g++) begin : gLeaf
            param_mux #(
                .RADIX      (RADIX),
                .DATA_WIDTH (DATA_WIDTH)
            ) uLeaf (
                .data (lanes[g*RADIX +: RADIX]),
                .sel  (in_sel[LEAF_SEL_W-1:0]),
                .y    (leafOut[g])
            );
        end

        // Pad the registered leaf results out to the root mux width.
        for (genvar g = 0; g < GRP_POW2; g++) begin : gRootIn
            if (g < GROUPS) begin : gUsed
                assign rootIn[g] = leafQ[g];
            end else begin : gPad
                assign rootIn[g] = '0;
            end
        end
    endgenerate

    param_mux #(
        .RADIX      (GRP_POW2),
        .DATA_WIDTH (DATA_WIDTH)
    ) uRoot (
        .data (rootIn),
        .sel  (s1Side.grp),
        .y    (rootOut)
    );

    // S1: capture leaf results and sideband when a beat is accepted; hold while S2 is blocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            vldPipe[1] <= 1'b0;
            leafQ      <= '0;
            s1Side     <= '0;
        end else if (s1Ready) begin
            vldPipe[1] <= in_valid;
            if (in_valid) begin
                leafQ  <= leafOut;
                s1Side <= '{err: selErr, grp: selGrp};
            end
        end
    end

    // S2: pick the group result, zero it on range error, hold it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            vldPipe[2] <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
        end else if (s2Ready) begin
            vldPipe[2] <= vldPipe[1];
            if (vldPipe[1]) begin
                out_data <= s1Side.err ? '0 : rootOut;
                out_err  <= s1Side.err;
            end
        end
    end

endmodule

// File: doc/pipelined_tree_mux.md
Name: pipelined_tree_mux

Overview:
- Parametrised, two-stage pipelined N-to-1 selector for the CAM datapath.
- Generalises the 32-to-1 selector with:
  - configurable input count, data width and leaf radix;
  - registered stages with valid/ready flow control;
  - out-of-range select detection.
- Sits between CAM match/data arrays and downstream consumers that may apply backpressure.

Parameters:
- NUM_INPUTS, 32, number of selectable input lanes. Must be a multiple of RADIX; need not be a power of 2.
- DATA_WIDTH, 1, bits per lane.
- RADIX, 8, lanes per leaf mux. Power of 2, ≥2.
- Derived localparam SEL_W = $clog2(NUM_INPUTS), minimum 1.
- Derived localparam GROUPS = NUM_INPUTS/RADIX.
- Derived localparam LEAF_SEL_W = $clog2(RADIX).
- Derived localparam GRP_SEL_W = max(1, $clog2(GROUPS)).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  NUM_INPUTS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_sel  in  SEL_W  lane index.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  DATA_WIDTH  selected lane.
- out_err  out  1  beat's in_sel was ≥ NUM_INPUTS.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - The producer holds in_data/in_sel stable while in_valid && !in_ready.
  - Same rule applies downstream with out_valid/out_ready.
- Stage 1 (S1), on accept:
  - Each of the GROUPS leaf muxes selects in_sel[LEAF_SEL_W-1:0] within its group.
  - Register all GROUPS leaf outputs.
  - Register group index = in_sel[SEL_W-1:LEAF_SEL_W]; zero-extend to GRP_SEL_W if needed.
  - Register err = (in_sel ≥ NUM_INPUTS).
- Stage 2 (S2):
  - Selects the registered leaf output by registered group index.
  - Registers out_data, out_err and out_valid.
  - If err, out_data = 0 regardless of lane contents.
- Latency: 2 cycles from accepted input to out_valid, with no stall.
- Throughput: 1 beat/cycle when out_ready is held high.
- Ready chain (combinational, no comb path from in_valid to in_ready):
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready && !reset.
- Stall: when out_valid && !out_ready:
  - S2 holds out_data and out_err stable.
  - S1 holds if full; one further beat may enter S1 if S1 was empty.
- Ordering: beats are never dropped, duplicated or reordered.
- Reset:
  - s1_valid = 0, out_valid = 0, out_data = 0, out_err = 0, S1 registers = 0.
  - in_ready = 0 while reset is high; it may assert the cycle after reset deasserts.
  - Reset mid-stream discards both in-flight beats with no output.
- Simultaneous out_ready and in_valid with both stages full: S2 drains, S1 advances and the new beat enters S1 on the same edge.
- Wrap/range:
  - When NUM_INPUTS is a power of 2, out_err is never set.
  - Otherwise any sel in [NUM_INPUTS, 2^SEL_W-1] sets out_err.
- GROUPS = 1: S2 is a pure register stage, and the group index is ignored except for err.
- Data registers carry no reset requirement beyond the zeroing stated above.

Decomposition:
- Package cam_mux_pkg holds:
  - function clog2_min1;
  - localparam DEFAULT_RADIX = 8;
  - typedef struct packed {logic err; logic [GRP_SEL_W-1:0] grp;} for the S1 sideband. This typedef is parameter-dependent, so it is declared in the module using package helpers.
- One sub-module, param_mux:
  - combinational RADIX-to-1 mux, DATA_WIDTH wide;
  - instantiated GROUPS times in S1;
  - reused with RADIX = GROUPS (rounded up to a power of 2, unused inputs tied 0) for S2.

Test Plan:
- Defaults, lane i = i[0], sweep in_sel 0..31 with out_ready = 1 → out_data = sel[0]; out_valid exactly 2 cycles after each accept; 32 consecutive beats.
- DATA_WIDTH = 8, lane i = 8'hA0+i; send sel = 5, 17, 31 while holding out_ready = 0 for 4 cycles → after 2 beats in_ready = 0 and out_data holds 8'hA5; on release, outputs A5, B1, BF in order.
- NUM_INPUTS = 24, RADIX = 8 (SEL_W = 5); send sel = 23, then 24, then 31 → out_data = lane 23 with out_err = 0, then out_data = 0 with out_err = 1, twice.
- Assert reset for 1 cycle with two beats in flight → next cycle out_valid = 0, out_data = 0, out_err = 0; in_ready = 0 during reset and 1 after.
- Random valid/ready toggling, 10k beats, against a scoreboard model → no loss, duplication or reorder; in_ready never depends on in_valid.
- GROUPS = 1 configuration (NUM_INPUTS = RADIX = 4) → latency 2, out_data = lane[sel].
